// File: rtl/ej32_pkg.sv
// Shared opcode encodings, width types and buffer base addresses for the ej32 core.
// Optional byte opcodes (baload/bastore) are enabled by defining EJ32_BYTE_OPS_EN.
package ej32_pkg;

  typedef logic        u1_t;
  typedef logic [1:0]  u2_t;
  typedef logic [2:0]  u3_t;
  typedef logic [4:0]  u5_t;
  typedef logic [7:0]  u8_t;
  typedef logic [31:0] u32_t;

  localparam u32_t TIB  = 32'h0000_1000;
  localparam u32_t OBUF = 32'h0000_1400;

  typedef enum logic [7:0] {
    OP_NOP       = 8'h00,
    OP_ICONST_M1 = 8'h02,
    OP_ICONST_5  = 8'h08,
    OP_BIPUSH    = 8'h10,
    OP_SIPUSH    = 8'h11,
    OP_IALOAD    = 8'h2e,
    OP_BALOAD    = 8'h33,
    OP_IASTORE   = 8'h4f,
    OP_BASTORE   = 8'h54,
    OP_POP       = 8'h57,
    OP_DUP       = 8'h59,
    OP_SWAP      = 8'h5f,
    OP_IADD      = 8'h60,
    OP_ISUB      = 8'h64,
    OP_IAND      = 8'h7e,
    OP_IOR       = 8'h80,
    OP_IXOR      = 8'h82,
    OP_IFEQ      = 8'h99,
    OP_GOTO      = 8'ha7,
    OP_RETURN    = 8'hb1,
    OP_INVOKE    = 8'hb6,
    OP_TIB       = 8'hcb,
    OP_OBUF      = 8'hcc,
    OP_ERR       = 8'hff
  } opcode_t;

  // Big-endian byte lane: index 0 is the most significant byte.
  function automatic u8_t byte_of(input u32_t w, input u2_t idx);
    case (idx)
      2'd0:    byte_of = w[31:24];
      2'd1:    byte_of = w[23:16];
      2'd2:    byte_of = w[15:8];
      default: byte_of = w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/ej32_stack.sv
// 32-deep, 32-bit LIFO with a wrapping 5-bit pointer; top_o is the entry below the pointer.
module ej32_stack
  import ej32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        repl_i,
  input  logic [31:0] din_i,
  output logic [31:0] top_o,
  output logic [4:0]  sp_o
);

  u32_t mem_q [32];
  u5_t  sp_q, sp_d;

  assign top_o = mem_q[sp_q - 5'd1];
  assign sp_o  = sp_q;

  always_comb begin
    sp_d = sp_q;
    if (push_i)     sp_d = sp_q + 5'd1;
    else if (pop_i) sp_d = sp_q - 5'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
      sp_q <= '0;
    end else begin
      if (push_i)      mem_q[sp_q] <= din_i;
      else if (repl_i) mem_q[sp_q - 5'd1] <= din_i;
      sp_q <= sp_d;
    end
  end

endmodule

// File: rtl/ej32.sv
// ej32: byte-bus stack-machine core running a JVM opcode subset as Forth primitives.
// Define EJ32_BYTE_OPS_EN to enable baload (0x33) and bastore (0x54).
module ej32
  import ej32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_i,
  output logic [31:0] addr_o,
  output logic [7:0]  data_o,
  output logic        dwe_o,
  output logic [31:0] t,
  output logic [7:0]  code,
  output logic [2:0]  phase_o,
  output logic [31:0] p_o,
  output logic [31:0] a_o,
  output logic [31:0] s_o,
  output logic [4:0]  sp_o,
  output logic [4:0]  rp_o
);

  u32_t t_q, t_d, a_q, a_d, p_q, p_d, rs_top, fetch_addr;
  u8_t  code_q, code_d;
  u3_t  phase_q, phase_d;
  logic ds_push, ds_pop, ds_repl, rs_push, rs_pop, fetch;

  function automatic u32_t alu(input u8_t op, input u32_t a, input u32_t b);
    case (op)
      OP_ISUB: alu = a - b;
      OP_IAND: alu = a & b;
      OP_IOR:  alu = a | b;
      OP_IXOR: alu = a ^ b;
      default: alu = a + b;
    endcase
  endfunction

  ej32_stack u_ds (
    .clk(clk), .rst(rst), .push_i(ds_push), .pop_i(ds_pop), .repl_i(ds_repl),
    .din_i(t_q), .top_o(s_o), .sp_o(sp_o)
  );

  ej32_stack u_rs (
    .clk(clk), .rst(rst), .push_i(rs_push), .pop_i(rs_pop), .repl_i(1'b0),
    .din_i(p_q), .top_o(rs_top), .sp_o(rp_o)
  );

  always_comb begin
    t_d = t_q; a_d = a_q; p_d = p_q; code_d = code_q;
    phase_d = phase_q + 3'd1;
    addr_o = p_q; data_o = '0; dwe_o = 1'b0;
    ds_push = 1'b0; ds_pop = 1'b0; ds_repl = 1'b0;
    rs_push = 1'b0; rs_pop = 1'b0;
    fetch = 1'b0; fetch_addr = p_q;
    case (code_q)
      OP_DUP:  begin ds_push = 1'b1; fetch = 1'b1; end
      OP_POP:  begin t_d = s_o; ds_pop = 1'b1; fetch = 1'b1; end
      OP_SWAP: begin t_d = s_o; ds_repl = 1'b1; fetch = 1'b1; end
      OP_IADD, OP_ISUB, OP_IAND, OP_IOR, OP_IXOR: begin
        t_d = alu(code_q, s_o, t_q); ds_pop = 1'b1; fetch = 1'b1;
      end
      OP_TIB:  begin t_d = TIB;  ds_push = 1'b1; fetch = 1'b1; end
      OP_OBUF: begin t_d = OBUF; ds_push = 1'b1; fetch = 1'b1; end
      OP_BIPUSH: begin
        if (phase_q == 3'd0) begin
          t_d = {{24{data_i[7]}}, data_i}; ds_push = 1'b1; p_d = p_q + 32'd1;
        end else fetch = 1'b1;
      end
      // Two-byte immediate forms share the operand read; phase 2 differs per opcode.
      OP_SIPUSH, OP_GOTO, OP_IFEQ, OP_INVOKE: begin
        if (phase_q != 3'd2) begin
          a_d = (phase_q == 3'd0) ? {24'b0, data_i} : {a_q[23:0], data_i};
          p_d = p_q + 32'd1;
        end else begin
          fetch = 1'b1;
          case (code_q)
            OP_SIPUSH: begin t_d = {{16{a_q[15]}}, a_q[15:0]}; ds_push = 1'b1; end
            OP_GOTO:   fetch_addr = a_q;
            OP_IFEQ: begin
              if (t_q == '0) fetch_addr = a_q;
              t_d = s_o; ds_pop = 1'b1;
            end
            OP_INVOKE: begin rs_push = 1'b1; fetch_addr = a_q; end
            default: ;
          endcase
        end
      end
      OP_RETURN: begin
        if (phase_q == 3'd0) begin rs_pop = 1'b1; p_d = rs_top; end
        else fetch = 1'b1;
      end
      OP_IALOAD: begin
        if (phase_q != 3'd4) begin
          addr_o = (phase_q == 3'd0) ? t_q : a_q + 32'(phase_q);
          if (phase_q == 3'd0) a_d = t_q;
          t_d = {t_q[23:0], data_i};
        end else fetch = 1'b1;
      end
      // Address stays in T through the writes; the two pops land on phases 3 and 4.
      OP_IASTORE: begin
        if (phase_q != 3'd4) begin
          addr_o = t_q + 32'(phase_q);
          data_o = byte_of(s_o, phase_q[1:0]);
          dwe_o  = 1'b1;
        end else fetch = 1'b1;
        if (phase_q >= 3'd3) begin t_d = s_o; ds_pop = 1'b1; end
      end
`ifdef EJ32_BYTE_OPS_EN
      OP_BALOAD: begin
        if (phase_q == 3'd0) begin addr_o = t_q; t_d = {24'b0, data_i}; end
        else fetch = 1'b1;
      end
      OP_BASTORE: begin
        if (phase_q == 3'd0) begin addr_o = t_q; data_o = s_o[7:0]; dwe_o = 1'b1; end
        else fetch = 1'b1;
        t_d = s_o; ds_pop = 1'b1;
      end
`endif
      default: begin
        if (code_q >= OP_ICONST_M1 && code_q <= OP_ICONST_5) begin
          t_d = {24'b0, code_q} - 32'd3; ds_push = 1'b1;
        end
        fetch = 1'b1;
      end
    endcase
    if (fetch) begin
      addr_o  = fetch_addr;
      code_d  = data_i;
      p_d     = fetch_addr + 32'd1;
      phase_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q <= '0; a_q <= '0; p_q <= '0; code_q <= OP_NOP; phase_q <= '0;
    end else begin
      t_q <= t_d; a_q <= a_d; p_q <= p_d; code_q <= code_d; phase_q <= phase_d;
    end
  end

  assign t       = t_q;
  assign code    = code_q;
  assign phase_o = phase_q;
  assign p_o     = p_q;
  assign a_o     = a_q;

endmodule

// File: tb/tb_ej32.sv
// Bench for ej32: instruction-level reference model checked at every instruction boundary,
// plus literal expectations for the directed programs.
module tb_ej32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_i, data_o, code;
  logic [31:0] addr_o, t, p_o, a_o, s_o;
  logic        dwe_o;
  logic [2:0]  phase_o;
  logic [4:0]  sp_o, rp_o;

  logic [7:0] mem [65536];
  assign data_i = mem[addr_o[15:0]];

  always #5 clk = ~clk;

  ej32 dut (
    .clk(clk), .rst(rst), .data_i(data_i), .addr_o(addr_o), .data_o(data_o),
    .dwe_o(dwe_o), .t(t), .code(code), .phase_o(phase_o), .p_o(p_o), .a_o(a_o),
    .s_o(s_o), .sp_o(sp_o), .rp_o(rp_o)
  );

  int n_pass = 0, n_tot = 0, dwe_cnt = 0;

  // Reference model state: architectural view only.
  logic [31:0] ms [32];
  logic [31:0] mrs [32];
  logic [31:0] mT, mP;
  logic [4:0]  mSP, mRP;
  logic [7:0]  mcode;
  logic [7:0]  mm [65536];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic put(input int a, input logic [7:0] b);
    mem[a] = b; mm[a] = b;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) begin mem[i] = 8'h00; mm[i] = 8'h00; end
  endtask

  // One clock: memory writes land at the falling edge, mid-cycle.
  task automatic tick();
    @(negedge clk);
    if (dwe_o) begin mem[addr_o[15:0]] = data_o; dwe_cnt++; end
    @(posedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".addr"}, addr_o, 32'd0);
    chk({tag, ".p"}, p_o, 32'd0);
    chk({tag, ".T"}, t, 32'd0);
    chk({tag, ".A"}, a_o, 32'd0);
    chk({tag, ".s"}, s_o, 32'd0);
    chk({tag, ".sp"}, 32'(sp_o), 32'd0);
    chk({tag, ".rp"}, 32'(rp_o), 32'd0);
    chk({tag, ".phase"}, 32'(phase_o), 32'd0);
    chk({tag, ".code"}, 32'(code), 32'd0);
    chk({tag, ".dwe"}, 32'(dwe_o), 32'd0);
    chk({tag, ".dout"}, 32'(data_o), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick(); #1;
    chk_reset_state("rst");
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin ms[i] = '0; mrs[i] = '0; end
    mT = '0; mP = '0; mSP = '0; mRP = '0; mcode = 8'h00;
    dwe_cnt = 0;
  endtask

  function automatic int m_cycles(input logic [7:0] op);
    case (op)
      8'h10, 8'hb1:               m_cycles = 2;
      8'h11, 8'ha7, 8'h99, 8'hb6: m_cycles = 3;
      8'h2e, 8'h4f:               m_cycles = 5;
`ifdef EJ32_BYTE_OPS_EN
      8'h33, 8'h54:               m_cycles = 2;
`endif
      default:                    m_cycles = 1;
    endcase
  endfunction

  task automatic m_push(input logic [31:0] v);
    ms[mSP] = mT; mSP = mSP + 5'd1; mT = v;
  endtask

  task automatic m_pop();
    mSP = mSP - 5'd1; mT = ms[mSP];
  endtask

  // Execute the current instruction as a whole, then fetch the next opcode.
  task automatic m_exec();
    logic [31:0] a, b, tgt;
    logic [15:0] pa;
    pa  = mP[15:0];
    tgt = {16'h0, mm[pa], mm[16'(pa + 16'd1)]};
    case (mcode)
      8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08: m_push(32'(int'(mcode) - 3));
      8'h59: m_push(mT);
      8'h57: m_pop();
      8'h5f: begin a = ms[mSP - 5'd1]; ms[mSP - 5'd1] = mT; mT = a; end
      8'h60, 8'h64, 8'h7e, 8'h80, 8'h82: begin
        b = mT; m_pop(); a = mT;
        case (mcode)
          8'h60:   mT = a + b;
          8'h64:   mT = a - b;
          8'h7e:   mT = a & b;
          8'h80:   mT = a | b;
          default: mT = a ^ b;
        endcase
      end
      8'h10: begin m_push({{24{mm[pa][7]}}, mm[pa]}); mP = mP + 1; end
      8'h11: begin mP = mP + 2; m_push({{16{tgt[15]}}, tgt[15:0]}); end
      8'ha7: mP = tgt;
      8'h99: begin mP = (mT == 32'd0) ? tgt : mP + 2; m_pop(); end
      8'hb6: begin mrs[mRP] = mP + 2; mRP = mRP + 5'd1; mP = tgt; end
      8'hb1: begin mRP = mRP - 5'd1; mP = mrs[mRP]; end
      8'h2e: begin
        a = mT;
        mT = {mm[a[15:0]], mm[16'(a + 1)], mm[16'(a + 2)], mm[16'(a + 3)]};
      end
      8'h4f: begin
        a = mT; b = ms[mSP - 5'd1];
        for (int i = 0; i < 4; i++) mm[16'(a + 32'(i))] = b[31 - 8*i -: 8];
        m_pop(); m_pop();
      end
      8'hcb: m_push(32'h1000);
      8'hcc: m_push(32'h1400);
`ifdef EJ32_BYTE_OPS_EN
      8'h33: mT = {24'h0, mm[mT[15:0]]};
      8'h54: begin mm[mT[15:0]] = ms[mSP - 5'd1][7:0]; m_pop(); m_pop(); end
`endif
      default: ;
    endcase
    mcode = mm[mP[15:0]];
    mP = mP + 1;
  endtask

  // Advance the DUT through the rest of the current instruction and compare.
  task automatic step(input int done);
    string pfx;
    pfx = $sformatf("op%02h", mcode);
    repeat (m_cycles(mcode) - done) tick();
    #1;
    m_exec();
    chk({pfx, ".p"}, p_o, mP);
    chk({pfx, ".T"}, t, mT);
    chk({pfx, ".s"}, s_o, ms[mSP - 5'd1]);
    chk({pfx, ".sp"}, 32'(sp_o), 32'(mSP));
    chk({pfx, ".rp"}, 32'(rp_o), 32'(mRP));
    chk({pfx, ".code"}, 32'(code), 32'(mcode));
    chk({pfx, ".phase"}, 32'(phase_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // iconst_3, iconst_4, iadd -> 7
    clear_mem();
    put(0, 8'h06); put(1, 8'h07); put(2, 8'h60);
    do_reset();
    repeat (4) step(0);
    chk("add.T", t, 32'd7);
    chk("add.sp", 32'(sp_o), 32'd1);
    chk("add.p", p_o, 32'd4);

    // bipush 0xff, sipush 0x1234
    clear_mem();
    put(0, 8'h10); put(1, 8'hff); put(2, 8'h11); put(3, 8'h12); put(4, 8'h34);
    do_reset();
    repeat (3) step(0);
    chk("imm.T", t, 32'h0000_1234);
    chk("imm.s", s_o, 32'hffff_ffff);
    chk("imm.sp", 32'(sp_o), 32'd2);

    // invokevirtual 0x0040, return
    clear_mem();
    put(0, 8'hb6); put(1, 8'h00); put(2, 8'h40); put(16'h40, 8'hb1);
    do_reset();
    step(0);
    tick(); tick(); #1;
    chk("call.phase", 32'(phase_o), 32'd2);
    chk("call.addr", addr_o, 32'h40);
    step(2);
    chk("call.rp", 32'(rp_o), 32'd1);
    step(0);
    chk("ret.p", p_o, 32'd4);
    chk("ret.rp", 32'(rp_o), 32'd0);

    // load deadbeef from 0x200, store to 0x100, load it back
    clear_mem();
    put(0, 8'h11); put(1, 8'h02); put(2, 8'h00); put(3, 8'h2e);
    put(4, 8'h11); put(5, 8'h01); put(6, 8'h00); put(7, 8'h4f);
    put(8, 8'h11); put(9, 8'h01); put(10, 8'h00); put(11, 8'h2e);
    put(16'h200, 8'hde); put(16'h201, 8'had); put(16'h202, 8'hbe); put(16'h203, 8'hef);
    do_reset();
    repeat (7) step(0);
    chk("st.m100", 32'(mem[16'h100]), 32'hde);
    chk("st.m101", 32'(mem[16'h101]), 32'had);
    chk("st.m102", 32'(mem[16'h102]), 32'hbe);
    chk("st.m103", 32'(mem[16'h103]), 32'hef);
    chk("st.dwe_cnt", 32'(dwe_cnt), 32'd4);
    chk("ld.T", t, 32'hdead_beef);

    // ifeq taken with T=0, not taken with T=5
    clear_mem();
    put(0, 8'h03); put(1, 8'h99); put(2, 8'h00); put(3, 8'h10);
    put(16'h10, 8'h08); put(16'h11, 8'h99); put(16'h12, 8'h00); put(16'h13, 8'h20);
    do_reset();
    repeat (3) step(0);
    chk("ifeq0.p", p_o, 32'h11);
    chk("ifeq0.sp", 32'(sp_o), 32'd0);
    repeat (2) step(0);
    chk("ifeq5.p", p_o, 32'h15);
    chk("ifeq5.sp", 32'(sp_o), 32'd0);

    // 33 pushes wrap sp, then reset mid-iastore
    clear_mem();
    for (int i = 0; i < 33; i++) put(i, 8'h04);
    put(33, 8'h4f);
    do_reset();
    repeat (34) step(0);
    chk("wrap.sp", 32'(sp_o), 32'd1);
    tick(); tick(); #1;
    chk("mid.phase", 32'(phase_o), 32'd2);
    chk("mid.dwe", 32'(dwe_o), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_state("abort");
    tick();
    chk("abort.dwe_cnt", 32'(dwe_cnt), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
